// File: rtl/rr_arb_mux_oh.sv
// Round-robin arbitrating one-hot mux: picks one of InputWidth valid/ready requesters,
// steers its payload through an AND-OR mux, and presents it on one output port.
module rr_arb_mux_oh #(
   parameter int  InputWidth = 8,
   parameter int  DataWidth  = 8,
   parameter int  OutputReg  = 1,
   localparam int IdxWidth   = $clog2(InputWidth)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [InputWidth-1:0]                 valid_i,
   input  logic [InputWidth-1:0][DataWidth-1:0]  data_i,
   output logic [InputWidth-1:0]                 ready_o,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [DataWidth-1:0]                  out_data_o,
   output logic [InputWidth-1:0]                 out_grant_o,
   output logic [IdxWidth-1:0]                   out_idx_o
);

   // Handshake: a transfer happens on an edge where valid and ready are both high;
   // ready never depends on the payload, and ready_o carries at most one set bit.

   logic [IdxWidth-1:0]   ptr_q;
   logic [InputWidth-1:0] gnt;
   logic [IdxWidth-1:0]   gnt_idx;
   logic [DataWidth-1:0]  mux_data;
   logic                  accept;
   logic                  xfer;
   logic                  found;
   int                    j;

   // Search starts at ptr_q and wraps; the first valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < InputWidth; k++) begin
         j = int'(ptr_q) + k;
         if (j >= InputWidth) j = j - InputWidth;
         if (!found && valid_i[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = IdxWidth'(j);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      mux_data = '0;
      for (int m = 0; m < InputWidth; m++) begin
         mux_data = mux_data | (data_i[m] & {DataWidth{gnt[m]}});
      end
   end

   assign ready_o = rst_i ? '0 : (gnt & {InputWidth{accept}});
   assign xfer    = |(valid_i & ready_o);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (xfer) begin
         ptr_q <= (gnt_idx == IdxWidth'(InputWidth - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   generate
      if (OutputReg != 0) begin : g_reg
         logic                  out_valid_q;
         logic [DataWidth-1:0]  out_data_q;
         logic [InputWidth-1:0] out_grant_q;
         logic [IdxWidth-1:0]   out_idx_q;

         // A draining slice can take a new payload on the same edge.
         assign accept = !out_valid_q | out_ready_i;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               out_valid_q <= 1'b0;
               out_data_q  <= '0;
               out_grant_q <= '0;
               out_idx_q   <= '0;
            end else if (xfer) begin
               out_valid_q <= 1'b1;
               out_data_q  <= mux_data;
               out_grant_q <= gnt;
               out_idx_q   <= gnt_idx;
            end else if (out_ready_i) begin
               out_valid_q <= 1'b0;
            end
         end

         assign out_valid_o = out_valid_q;
         assign out_data_o  = out_data_q;
         assign out_grant_o = out_grant_q;
         assign out_idx_o   = out_idx_q;
      end else begin : g_comb
         assign accept      = out_ready_i;
         assign out_valid_o = !rst_i && (|valid_i);
         assign out_data_o  = rst_i ? '0 : mux_data;
         assign out_grant_o = rst_i ? '0 : gnt;
         assign out_idx_o   = rst_i ? '0 : gnt_idx;
      end
   endgenerate

   a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(ready_o));
   a_grant_onehot0: assert property (@(posedge clk_i) $onehot0(out_grant_o));
   a_gnt_onehot0:   assert property (@(posedge clk_i) $onehot0(gnt));

endmodule

// File: tb/tb_rr_arb_mux_oh.sv
// Directed and randomised bench for rr_arb_mux_oh: registered instance plus a
// combinational-mode instance sharing clock and reset.
module tb_rr_arb_mux_oh;
   localparam int N = 8;
   localparam int W = 8;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [N-1:0]        valid_i, ready_o, out_grant_o;
   logic [N-1:0][W-1:0] data_i;
   logic                out_valid_o, out_ready_i;
   logic [W-1:0]        out_data_o;
   logic [2:0]          out_idx_o;

   logic [N-1:0]        c_valid, c_ready_o, c_grant;
   logic [N-1:0][W-1:0] c_data;
   logic                c_out_valid, c_out_ready;
   logic [W-1:0]        c_out_data;
   logic [2:0]          c_idx;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   rr_arb_mux_oh #(.InputWidth(N), .DataWidth(W), .OutputReg(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_grant_o(out_grant_o), .out_idx_o(out_idx_o));

   rr_arb_mux_oh #(.InputWidth(N), .DataWidth(W), .OutputReg(0)) dut_c (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(c_valid), .data_i(c_data),
      .ready_o(c_ready_o), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
      .out_data_o(c_out_data), .out_grant_o(c_grant), .out_idx_o(c_idx));

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic load_rotation_data();
      for (int k = 0; k < N; k++) data_i[k] = W'(8'h10 + k);
   endtask

   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
      end
      return '0;
   endfunction

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 8'hFF; out_ready_i = 1'b0;
      load_rotation_data();
      c_valid = '0; c_data = '0; c_out_ready = 1'b0;
      tick(); tick();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid_o); end
      checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data_o); end
      checks++; if (out_grant_o !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h want 00", out_grant_o); end
      checks++; if (out_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx_o); end
      checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL reset_ready: got %h want 00", ready_o); end
      checks++; if (dut.ptr_q !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
      checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %0b want 0", c_out_valid); end
      rst_i = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      valid_i = 8'hFF; out_ready_i = 1'b0;
      settle();
      checks++; if (ready_o !== 8'h01) begin errors++; $display("FAIL stall_ready: got %h want 01", ready_o); end
      tick();
      valid_i = '0;
      settle();
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10) begin errors++; $display("FAIL stall_loaded: got v=%0b d=%h want v=1 d=10", out_valid_o, out_data_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      settle();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rst_valid: got %0b want 0", out_valid_o); end
      checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL stall_rst_data: got %h want 00", out_data_o); end
      checks++; if (dut.ptr_q !== 3'd0) begin errors++; $display("FAIL stall_rst_ptr: got %0d want 0", dut.ptr_q); end
      valid_i = 8'hFF; out_ready_i = 1'b1;
      settle();
      checks++; if (ready_o !== 8'h01) begin errors++; $display("FAIL stall_regrant: got %h want 01", ready_o); end
      tick();
      valid_i = '0;
      checks++; if (out_idx_o !== 3'd0 || out_data_o !== 8'h10) begin errors++; $display("FAIL stall_out: got i=%0d d=%h want i=0 d=10", out_idx_o, out_data_o); end
      tick();
   endtask

   task automatic test_full_rotation();
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      valid_i = 8'hFF; out_ready_i = 1'b1;
      settle();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rot_latency: got %0b want 0", out_valid_o); end
      for (int k = 0; k <= N; k++) begin
         tick();
         checks++;
         if (out_valid_o !== 1'b1 || out_data_o !== W'(8'h10 + (k % N)) || out_idx_o !== 3'(k % N)
             || out_grant_o !== (N'(1) << (k % N))) begin
            errors++;
            $display("FAIL rot_step%0d: got v=%0b d=%h i=%0d g=%h want v=1 d=%h i=%0d", k, out_valid_o,
                     out_data_o, out_idx_o, out_grant_o, 8'h10 + (k % N), k % N);
         end
      end
      valid_i = '0;
      tick();
   endtask

   task automatic test_sparse_wrap();
      int exp_g[3] = '{0, 2, 0};
      int exp_p[3] = '{1, 3, 1};
      valid_i = 8'b0010_0000; out_ready_i = 1'b1;
      tick();
      checks++; if (dut.ptr_q !== 3'd6) begin errors++; $display("FAIL sparse_setup_ptr: got %0d want 6", dut.ptr_q); end
      valid_i = 8'b0000_0101;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if (ready_o !== (N'(1) << exp_g[i])) begin errors++; $display("FAIL sparse_ready%0d: got %h want %h", i, ready_o, N'(1) << exp_g[i]); end
         tick();
         checks++; if (dut.ptr_q !== 3'(exp_p[i]) || out_idx_o !== 3'(exp_g[i])) begin
            errors++; $display("FAIL sparse_step%0d: got p=%0d i=%0d want p=%0d i=%0d", i, dut.ptr_q, out_idx_o, exp_p[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      valid_i = 8'hFF; out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         checks++; if (ready_o !== 8'h00) begin errors++; $display("FAIL bp_ready%0d: got %h want 00", i, ready_o); end
         tick();
         checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10 || out_grant_o !== 8'h01 || dut.ptr_q !== 3'd1) begin
            errors++; $display("FAIL bp_hold%0d: got v=%0b d=%h g=%h p=%0d want v=1 d=10 g=01 p=1", i, out_valid_o, out_data_o, out_grant_o, dut.ptr_q);
         end
      end
      out_ready_i = 1'b1;
      settle();
      checks++; if (ready_o !== 8'h02) begin errors++; $display("FAIL bp_release_ready: got %h want 02", ready_o); end
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h11 || out_idx_o !== 3'd1 || dut.ptr_q !== 3'd2) begin
         errors++; $display("FAIL bp_swap: got v=%0b d=%h i=%0d p=%0d want v=1 d=11 i=1 p=2", out_valid_o, out_data_o, out_idx_o, dut.ptr_q);
      end
      valid_i = '0;
      tick();
      checks++; if (out_valid_o !== 1'b0 || out_data_o !== 8'h11) begin errors++; $display("FAIL bp_drain: got v=%0b d=%h want v=0 d=11", out_valid_o, out_data_o); end
   endtask

   task automatic test_comb_mode();
      c_data = '0; c_data[2] = 8'h33; c_valid = 8'b0000_0100; c_out_ready = 1'b1;
      tick();
      checks++; if (dut_c.ptr_q !== 3'd3) begin errors++; $display("FAIL comb_setup_ptr: got %0d want 3", dut_c.ptr_q); end
      c_data = '0; c_data[7] = 8'hA5; c_valid = 8'b1000_0000; c_out_ready = 1'b0;
      settle();
      checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hA5 || c_idx !== 3'd7 || c_grant !== 8'h80) begin
         errors++; $display("FAIL comb_out: got v=%0b d=%h i=%0d g=%h want v=1 d=a5 i=7 g=80", c_out_valid, c_out_data, c_idx, c_grant);
      end
      checks++; if (c_ready_o !== 8'h00) begin errors++; $display("FAIL comb_stall_ready: got %h want 00", c_ready_o); end
      c_out_ready = 1'b1;
      settle();
      checks++; if (c_ready_o !== 8'h80) begin errors++; $display("FAIL comb_ready: got %h want 80", c_ready_o); end
      tick();
      checks++; if (dut_c.ptr_q !== 3'd0) begin errors++; $display("FAIL comb_wrap_ptr: got %0d want 0", dut_c.ptr_q); end
      c_valid = '0;
      settle();
      checks++; if (c_out_valid !== 1'b0 || c_out_data !== 8'h00) begin errors++; $display("FAIL comb_idle: got v=%0b d=%h want v=0 d=00", c_out_valid, c_out_data); end
   endtask

   task automatic test_random_soak();
      logic [N-1:0]        pend;
      logic [N-1:0][W-1:0] pdata;
      logic [N-1:0]        exp_ready;
      int                  waitc[N];
      int                  m_ptr, g;
      logic                m_full;
      logic [W-1:0]        exp_d;
      rst_i = 1'b1; valid_i = '0; tick(); rst_i = 1'b0;
      m_ptr = 0; m_full = 1'b0; pend = '0; pdata = '0;
      for (int k = 0; k < N; k++) waitc[k] = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k] = 1'b1;
               pdata[k] = W'($urandom);
            end
            data_i[k] = pend[k] ? pdata[k] : W'($urandom);
         end
         valid_i = pend;
         out_ready_i = ($urandom_range(0, 3) != 0);
         settle();
         exp_ready = (!m_full || out_ready_i) ? rr_pick(pend, m_ptr) : '0;
         checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL soak_ready c%0d: got %h want %h", cyc, ready_o, exp_ready); end
         checks++; if (out_valid_o !== m_full) begin errors++; $display("FAIL soak_valid c%0d: got %0b want %0b", cyc, out_valid_o, m_full); end
         if (m_full && out_ready_i) begin
            exp_d = exp_q.pop_front();
            checks++; if (out_data_o !== exp_d) begin errors++; $display("FAIL soak_data c%0d: got %h want %h", cyc, out_data_o, exp_d); end
         end
         if (exp_ready != '0) begin
            g = 0;
            for (int k = 0; k < N; k++) if (exp_ready[k]) g = k;
            exp_q.push_back(pdata[g]);
            for (int k = 0; k < N; k++) begin
               if (k != g && pend[k]) begin
                  waitc[k]++;
                  checks++; if (waitc[k] > N - 1) begin errors++; $display("FAIL soak_starve c%0d r%0d: got %0d want <=7", cyc, k, waitc[k]); end
               end
            end
            waitc[g] = 0;
            pend[g] = 1'b0;
            m_ptr = (g + 1) % N;
            m_full = 1'b1;
         end else if (out_ready_i) begin
            m_full = 1'b0;
         end
         tick();
      end
      valid_i = '0; out_ready_i = 1'b1;
      settle();
      if (m_full) begin
         exp_d = exp_q.pop_front();
         checks++; if (out_data_o !== exp_d) begin errors++; $display("FAIL soak_final_data: got %h want %h", out_data_o, exp_d); end
      end
      tick();
      checks++; if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL soak_leftover: got q=%0d v=%0b want q=0 v=0", exp_q.size(), out_valid_o); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_stall();
      test_full_rotation();
      test_sparse_wrap();
      test_backpressure();
      test_comb_mode();
      test_random_soak();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
